// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with column synchroniser, press/release debounce and two-digit history.
// Optional macro KEYPAD_MULTIKEY_REJECT_EN: multi-column patterns are treated as no key.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV  = 4000,
  parameter int DB_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] s0,
  output logic [3:0] s1
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2, RELEASE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, csync_q;
  logic [3:0]    row_q, row_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [DW-1:0] db_q, db_d;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    s0_q, s0_d, s1_q, s1_d;
  logic          no_key_s, match_s;

  function automatic logic is_multi(input logic [3:0] pat);
    return (pat & (pat - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [1:0] first_col(input logic [3:0] pat);
    if (pat[0])      return 2'd0;
    else if (pat[1]) return 2'd1;
    else if (pat[2]) return 2'd2;
    else             return 2'd3;
  endfunction

  function automatic logic [3:0] decode(input logic [3:0] row_oh, input logic [3:0] pat);
    logic [1:0] r;
    if (row_oh[0])      r = 2'd0;
    else if (row_oh[1]) r = 2'd1;
    else if (row_oh[2]) r = 2'd2;
    else                r = 2'd3;
    case ({r, first_col(pat)})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  4'hF: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

`ifdef KEYPAD_MULTIKEY_REJECT_EN
  assign no_key_s = (csync_q == 4'd0) || is_multi(csync_q);
  assign match_s  = (csync_q == cap_q) && !is_multi(csync_q);
`else
  assign no_key_s = (csync_q == 4'd0);
  assign match_s  = (csync_q == cap_q);
`endif

  // Next-state and output logic for the scan/debounce FSM.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    slot_d      = slot_q;
    db_d        = db_q;
    cap_d       = cap_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    case (state_q)
      SCAN: begin
        if (slot_q != SLOT_LAST) begin
          slot_d = slot_q + SW'(1);
        end else if (no_key_s) begin
          row_d  = {row_q[2:0], row_q[3]};
          slot_d = '0;
        end else begin
          cap_d   = csync_q;
          db_d    = '0;
          slot_d  = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!match_s) begin
          row_d   = {row_q[2:0], row_q[3]};
          slot_d  = '0;
          state_d = SCAN;
        end else if (db_q == DB_LAST) begin
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          key_code_d  = decode(row_q, cap_q);
          s0_d        = decode(row_q, cap_q);
          s1_d        = s0_q;
          state_d     = HELD;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      HELD: begin
        if (csync_q == 4'd0) begin
          db_d    = '0;
          state_d = RELEASE;
        end else begin
          state_d = HELD;
        end
      end
      RELEASE: begin
        if (csync_q != 4'd0) begin
          db_d    = '0;
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          key_held_d = 1'b0;
          row_d      = {row_q[2:0], row_q[3]};
          slot_d     = '0;
          state_d    = SCAN;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      default: begin
        state_d = SCAN;
        row_d   = 4'b0001;
        slot_d  = '0;
      end
    endcase
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      sync1_q     <= 4'd0;
      csync_q     <= 4'd0;
      row_q       <= 4'b0001;
      slot_q      <= '0;
      db_q        <= '0;
      cap_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      s0_q        <= 4'd0;
      s1_q        <= 4'd0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= col;
      csync_q     <= sync1_q;
      row_q       <= row_d;
      slot_q      <= slot_d;
      db_q        <= db_d;
      cap_q       <= cap_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign s0        = s0_q;
  assign s1        = s1_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench: a physical keypad model drives the columns, expected key events are queued per press.
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV  = 4;
  localparam int DB_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col, row, key_code, s0, s1;
  logic       key_valid, key_held;
  logic [15:0] pressed;   // bit r*4+c = key at row r, column c is closed

  typedef struct { logic [3:0] code; logic [3:0] e_s0; logic [3:0] e_s1; } ev_t;
  ev_t        exp_q[$];
  logic [3:0] mdl_s0;
  logic [3:0] kmap [16];
  int checks = 0, failures = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .s0(s0), .s1(s1)
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed key connects its row to its column.
  always_comb begin
    col = 4'd0;
    for (int r = 0; r < 4; r++)
      if (row[r]) col = col | pressed[r*4 +: 4];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every key_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_event: got key_code %0h expected no event at %0t", key_code, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_key_code", {28'd0, key_code}, {28'd0, e.code});
        check("ev_s0", {28'd0, s0}, {28'd0, e.e_s0});
        check("ev_s1", {28'd0, s1}, {28'd0, e.e_s1});
        check("ev_key_held", {31'd0, key_held}, 32'd1);
      end
    end
  end

  task automatic expect_key(input int r, input int c);
    ev_t e;
    e.code = kmap[r*4 + c];
    e.e_s1 = mdl_s0;
    e.e_s0 = e.code;
    mdl_s0 = e.code;
    exp_q.push_back(e);
  endtask

  task automatic gap_and_check(input int n);
    pressed = 16'd0;
    repeat (n) @(negedge clk);
    check("held_after_release", {31'd0, key_held}, 32'd0);
  endtask

  task automatic press(input int r, input int c, input int cycles);
    pressed = 16'd0;
    pressed[r*4 + c] = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] want);
    int n = 0;
    while (row !== want && n < 40) begin @(negedge clk); n++; end
    if (row !== want) begin
      checks++; failures++;
      $display("FAIL wait_row: got %b expected %b within 40 cycles", row, want);
    end
  endtask

  initial begin
    kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    pressed = 16'd0;
    mdl_s0  = 4'd0;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_row", {28'd0, row}, 32'h1);
    check("rst_key_code", {28'd0, key_code}, 32'h0);
    check("rst_key_valid", {31'd0, key_valid}, 32'h0);
    check("rst_key_held", {31'd0, key_held}, 32'h0);
    check("rst_s0", {28'd0, s0}, 32'h0);
    check("rst_s1", {28'd0, s1}, 32'h0);
    reset = 1'b0;

    // Idle scan: each row lasts SCAN_DIV cycles, rotating 0001..1000.
    for (int k = 0; k < 20; k++) begin
      check("idle_row", {28'd0, row}, 32'(1 << ((k / SCAN_DIV) % 4)));
      @(negedge clk);
    end

    expect_key(2, 1); press(2, 1, 60); gap_and_check(30);   // key 8
    check("resume_row", {28'd0, row}, 32'h8);
    expect_key(1, 1); press(1, 1, 60); gap_and_check(30);   // key 5
    expect_key(0, 2); press(0, 2, 60); gap_and_check(30);   // key 3

    // Contact bounce on row 0: never stable long enough to be accepted.
    wait_row(4'b0001);
    for (int b = 0; b < 2; b++) begin
      press(0, 0, 2);
      pressed = 16'd0;
      repeat (2) @(negedge clk);
    end
    gap_and_check(30);

    // Two keys on row 3 (columns 0 and 1).
`ifndef KEYPAD_MULTIKEY_REJECT_EN
    expect_key(3, 0);
`endif
    pressed = 16'd0;
    pressed[12] = 1'b1;
    pressed[13] = 1'b1;
    repeat (60) @(negedge clk);
    gap_and_check(30);

    // Random presses: long ones give exactly one event, short ones none.
    for (int i = 0; i < 25; i++) begin
      int k;
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 2) != 0) begin
        expect_key(k / 4, k % 4);
        press(k / 4, k % 4, 60 + $urandom_range(0, 40));
      end else begin
        press(k / 4, k % 4, $urandom_range(1, 5));
      end
      gap_and_check(30);
    end

    // Reset in the middle of debouncing key 1, key kept pressed.
    wait_row(4'b1000);
    wait_row(4'b0001);
    pressed = 16'd0;
    pressed[0] = 1'b1;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_row", {28'd0, row}, 32'h1);
    check("mid_rst_key_code", {28'd0, key_code}, 32'h0);
    check("mid_rst_key_valid", {31'd0, key_valid}, 32'h0);
    check("mid_rst_key_held", {31'd0, key_held}, 32'h0);
    check("mid_rst_s0", {28'd0, s0}, 32'h0);
    check("mid_rst_s1", {28'd0, s1}, 32'h0);
    check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    mdl_s0 = 4'd0;
    expect_key(0, 0);
    repeat (60) @(negedge clk);
    gap_and_check(30);

    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
